// File: rtl/id_ex_alu_decoder.sv
// id_ex_alu_decoder: decodes the IF/ID MIPS instruction into the ID/EX register and detects load-use hazards.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN builds a sticky flag for unsupported instructions.
module id_ex_alu_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        id_valid,
    input  logic        ex_stall,
    input  logic        flush,
    output logic [3:0]  aluop,
    output logic        alusrc,
    output logic [31:0] imm_ext,
    output logic [4:0]  dest,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        branch,
    output logic        ex_valid,
    output logic        hazard_stall,
    output logic        illegal
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [3:0] ALU_ADDU  = 4'b0000;
    localparam logic [3:0] ALU_SUBU  = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_ADDI  = 4'b0110;
    localparam logic [3:0] ALU_ADDIU = 4'b0111;
    localparam logic [3:0] ALU_ANDI  = 4'b1000;
    localparam logic [3:0] ALU_ORI   = 4'b1001;
    localparam logic [3:0] ALU_LUI   = 4'b1010;
    localparam logic [3:0] ALU_LW    = 4'b1011;
    localparam logic [3:0] ALU_SW    = 4'b1100;
    localparam logic [3:0] ALU_BEQ   = 4'b1101;

    typedef struct packed {
        logic        ex_valid;
        logic [3:0]  aluop;
        logic        alusrc;
        logic [31:0] imm_ext;
        logic [4:0]  dest;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        branch;
    } idex_t;

    localparam idex_t BUBBLE = '0;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] sext;
    logic [31:0] zext;
    logic        legal;
    logic        reads_rt;
    idex_t       dec;
    idex_t       load;
    idex_t       idex_d;
    idex_t       idex_q;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign sext   = {{16{instr[15]}}, instr[15:0]};
    assign zext   = {16'h0000, instr[15:0]};

    // Decode the IF/ID word into a full ID/EX entry and classify it as supported or not.
    always_comb begin
        dec   = BUBBLE;
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec.dest     = rd;
                dec.regwrite = 1'b1;
                legal        = 1'b1;
                case (funct)
                    F_ADDU:  dec.aluop = ALU_ADDU;
                    F_SUBU:  dec.aluop = ALU_SUBU;
                    F_ADD:   dec.aluop = ALU_ADD;
                    F_AND:   dec.aluop = ALU_AND;
                    F_OR:    dec.aluop = ALU_OR;
                    F_SLT:   dec.aluop = ALU_SLT;
                    // The all-zero word is the canonical nop; other unknown functs are unsupported.
                    default: legal = (instr == 32'h0);
                endcase
            end
            OP_ADDI: begin
                legal        = 1'b1;
                dec.aluop    = ALU_ADDI;
                dec.alusrc   = 1'b1;
                dec.imm_ext  = sext;
                dec.dest     = rt;
                dec.regwrite = 1'b1;
            end
            OP_ADDIU: begin
                legal        = 1'b1;
                dec.aluop    = ALU_ADDIU;
                dec.alusrc   = 1'b1;
                dec.imm_ext  = sext;
                dec.dest     = rt;
                dec.regwrite = 1'b1;
            end
            OP_ANDI: begin
                legal        = 1'b1;
                dec.aluop    = ALU_ANDI;
                dec.alusrc   = 1'b1;
                dec.imm_ext  = zext;
                dec.dest     = rt;
                dec.regwrite = 1'b1;
            end
            OP_ORI: begin
                legal        = 1'b1;
                dec.aluop    = ALU_ORI;
                dec.alusrc   = 1'b1;
                dec.imm_ext  = zext;
                dec.dest     = rt;
                dec.regwrite = 1'b1;
            end
            OP_LUI: begin
                legal        = 1'b1;
                dec.aluop    = ALU_LUI;
                dec.alusrc   = 1'b1;
                dec.imm_ext  = zext;
                dec.dest     = rt;
                dec.regwrite = 1'b1;
            end
            OP_LW: begin
                legal        = 1'b1;
                dec.aluop    = ALU_LW;
                dec.alusrc   = 1'b1;
                dec.imm_ext  = sext;
                dec.dest     = rt;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
            end
            OP_SW: begin
                legal        = 1'b1;
                dec.aluop    = ALU_SW;
                dec.alusrc   = 1'b1;
                dec.imm_ext  = sext;
                dec.memwrite = 1'b1;
            end
            OP_BEQ: begin
                legal       = 1'b1;
                dec.aluop   = ALU_BEQ;
                dec.imm_ext = sext;
                dec.branch  = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        dec.regwrite = dec.regwrite & (dec.dest != 5'd0);
        dec.ex_valid = 1'b1;
    end

    assign reads_rt = (opcode == OP_RTYPE) | (opcode == OP_SW) | (opcode == OP_BEQ);

    assign hazard_stall = idex_q.ex_valid & idex_q.memread & (idex_q.dest != 5'd0) & id_valid &
                          ((idex_q.dest == rs) | (reads_rt & (idex_q.dest == rt)));

    // Invalid or unsupported words enter ID/EX as bubbles so no stray control reaches EX.
    assign load = (id_valid & legal) ? dec : BUBBLE;

    // ID/EX next state: flush beats stall, stall beats the load-use bubble.
    always_comb begin
        idex_d = flush ? BUBBLE : ex_stall ? idex_q : hazard_stall ? BUBBLE : load;
    end

    // ID/EX register.
    always_ff @(posedge clk) begin
        if (rst) idex_q <= BUBBLE;
        else     idex_q <= idex_d;
    end

    assign aluop    = idex_q.aluop;
    assign alusrc   = idex_q.alusrc;
    assign imm_ext  = idex_q.imm_ext;
    assign dest     = idex_q.dest;
    assign regwrite = idex_q.regwrite;
    assign memread  = idex_q.memread;
    assign memwrite = idex_q.memwrite;
    assign memtoreg = idex_q.memtoreg;
    assign branch   = idex_q.branch;
    assign ex_valid = idex_q.ex_valid;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_d;
    logic illegal_q;

    // Latch on an unsupported word only when it would actually have been loaded.
    always_comb begin
        illegal_d = illegal_q | (~flush & ~ex_stall & ~hazard_stall & id_valid & ~legal);
    end

    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_id_ex_alu_decoder.sv
// tb_id_ex_alu_decoder: directed vectors, corner sequences and random stimulus against a table-driven reference model.
module tb_id_ex_alu_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        id_valid;
    logic        ex_stall;
    logic        flush;
    logic [3:0]  aluop;
    logic        alusrc;
    logic [31:0] imm_ext;
    logic [4:0]  dest;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        branch;
    logic        ex_valid;
    logic        hazard_stall;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    id_ex_alu_decoder dut (
        .clk(clk), .rst(rst), .instr(instr), .id_valid(id_valid), .ex_stall(ex_stall), .flush(flush),
        .aluop(aluop), .alusrc(alusrc), .imm_ext(imm_ext), .dest(dest), .regwrite(regwrite),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg), .branch(branch),
        .ex_valid(ex_valid), .hazard_stall(hazard_stall), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ev;
        logic [3:0]  op;
        logic        src;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        mt;
        logic        br;
    } st_t;

    typedef struct {
        logic [31:0] ins;
        st_t         e;
    } vec_t;

    // Supported encodings; the row index is the aluop. Kind: 0 R-type, 1 sign-ext arith, 2 zero-ext logic, 3 lw, 4 sw, 5 beq.
    localparam logic [5:0] CODE [14] = '{6'h21, 6'h23, 6'h20, 6'h24, 6'h25, 6'h2a,
                                         6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04};
    localparam int KIND [14] = '{0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 2, 3, 4, 5};

    st_t  m;
    logic ill;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] f);
        return {6'h00, rs, rt, rd, 5'd0, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, output logic ok, output st_t d);
        logic [31:0] sx;
        logic [31:0] zx;
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0, ins[15:0]};
        d  = '0;
        ok = (ins == 32'h0);
        d.ev = ok;
        for (int i = 0; i < 14; i++) begin
            if (KIND[i] == 0 ? (ins[31:26] == 6'h00 && ins[5:0] == CODE[i]) : (ins[31:26] == CODE[i])) begin
                ok   = 1'b1;
                d.ev = 1'b1;
                d.op = 4'(i);
                case (KIND[i])
                    0: begin d.dst = ins[15:11]; d.rw = 1'b1; end
                    1: begin d.imm = sx; d.src = 1'b1; d.dst = ins[20:16]; d.rw = 1'b1; end
                    2: begin d.imm = zx; d.src = 1'b1; d.dst = ins[20:16]; d.rw = 1'b1; end
                    3: begin d.imm = sx; d.src = 1'b1; d.dst = ins[20:16]; d.rw = 1'b1; d.mr = 1'b1; d.mt = 1'b1; end
                    4: begin d.imm = sx; d.src = 1'b1; d.mw = 1'b1; end
                    default: begin d.imm = sx; d.br = 1'b1; end
                endcase
                d.rw = d.rw && (d.dst != 5'd0);
            end
        end
    endfunction

    function automatic logic model_haz(input logic [31:0] ins, input logic idv);
        logic rdrt;
        rdrt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2b) || (ins[31:26] == 6'h04);
        return m.ev && m.mr && (m.dst != 5'd0) && idv &&
               ((m.dst == ins[25:21]) || (rdrt && (m.dst == ins[20:16])));
    endfunction

    function automatic st_t dut_st();
        return {ex_valid, aluop, alusrc, imm_ext, dest, regwrite, memread, memwrite, memtoreg, branch};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_model();
        logic exp_ill;
`ifdef DECODE_ILLEGAL_TRAP_EN
        exp_ill = ill;
`else
        exp_ill = 1'b0;
`endif
        chk("idex_vs_model", 64'(dut_st()), 64'(m));
        chk("illegal_vs_model", 64'(illegal), 64'(exp_ill));
    endtask

    // One cycle: drive at posedge+1, check hazard at the negedge, advance model at the edge, check at posedge+1.
    task automatic cyc(input logic [31:0] ins, input logic idv, st, fl, r, output logic hz);
        logic ok;
        st_t  d;
        logic h;
        instr = ins; id_valid = idv; ex_stall = st; flush = fl; rst = r;
        #4;
        h  = model_haz(ins, idv);
        hz = hazard_stall;
        chk("hazard_vs_model", 64'(hazard_stall), 64'(h));
        @(posedge clk);
        ref_decode(ins, ok, d);
        if (r) begin
            m = '0; ill = 1'b0;
        end else if (fl) begin
            m = '0;
        end else if (!st) begin
            if (h) m = '0;
            else begin
                m = (idv && ok) ? d : '0;
                if (idv && !ok) ill = 1'b1;
            end
        end
        #1;
        chk_model();
    endtask

    vec_t vt [17];
    logic hz;
    logic [31:0] ADDU_DEP;
    logic [31:0] LW_T0;
    logic [31:0] ADDI_N4;

    initial begin
        m = '0; ill = 1'b0;
        ADDU_DEP = 32'h010B5021;
        LW_T0    = 32'h8D280000;
        ADDI_N4  = 32'h2128FFFC;
        vt[0]  = '{enc_r(9, 11, 10, 6'h21), '{1'b1, 4'd0, 1'b0, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[1]  = '{enc_r(9, 11, 12, 6'h23), '{1'b1, 4'd1, 1'b0, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[2]  = '{enc_r(9, 11, 13, 6'h20), '{1'b1, 4'd2, 1'b0, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[3]  = '{enc_r(9, 11, 14, 6'h24), '{1'b1, 4'd3, 1'b0, 32'h0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[4]  = '{enc_r(9, 11, 15, 6'h25), '{1'b1, 4'd4, 1'b0, 32'h0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[5]  = '{enc_r(9, 11, 16, 6'h2a), '{1'b1, 4'd5, 1'b0, 32'h0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[6]  = '{32'h2128FFFC,             '{1'b1, 4'd6, 1'b1, 32'hFFFFFFFC, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[7]  = '{enc_i(6'h09, 9, 8, 16'h7FFF), '{1'b1, 4'd7, 1'b1, 32'h00007FFF, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[8]  = '{enc_i(6'h0c, 9, 8, 16'h8000), '{1'b1, 4'd8, 1'b1, 32'h00008000, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[9]  = '{enc_i(6'h0d, 9, 8, 16'hF0F0), '{1'b1, 4'd9, 1'b1, 32'h0000F0F0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[10] = '{enc_i(6'h0f, 0, 8, 16'h1234), '{1'b1, 4'd10, 1'b1, 32'h00001234, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[11] = '{enc_i(6'h23, 9, 2, 16'hFFF0), '{1'b1, 4'd11, 1'b1, 32'hFFFFFFF0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}};
        vt[12] = '{enc_i(6'h2b, 9, 8, 16'h0004), '{1'b1, 4'd12, 1'b1, 32'h00000004, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        vt[13] = '{enc_i(6'h04, 9, 8, 16'hFFFF), '{1'b1, 4'd13, 1'b0, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
        vt[14] = '{32'h00000000,             '{1'b1, 4'd0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[15] = '{enc_r(9, 10, 0, 6'h21),   '{1'b1, 4'd0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[16] = '{32'hFC000000,             '{1'b0, 4'd0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};

        cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, hz);
        cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, hz);
        chk("reset_state", 64'(dut_st()), 64'h0);
        chk("reset_illegal", 64'(illegal), 64'h0);

        for (int i = 0; i < 17; i++) begin
            cyc(vt[i].ins, 1'b1, 1'b0, 1'b0, 1'b0, hz);
            chk($sformatf("vec%0d", i), 64'(dut_st()), 64'(vt[i].e));
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("illegal_set", 64'(illegal), 64'h1);
        cyc(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, hz);
        chk("illegal_sticky", 64'(illegal), 64'h1);
`else
        chk("illegal_tied", 64'(illegal), 64'h0);
`endif

        cyc(LW_T0, 1'b1, 1'b0, 1'b0, 1'b0, hz);
        cyc(ADDU_DEP, 1'b1, 1'b0, 1'b0, 1'b0, hz);
        chk("lduse_haz", 64'(hz), 64'h1);
        chk("lduse_bubble", 64'(ex_valid), 64'h0);
        cyc(ADDU_DEP, 1'b1, 1'b0, 1'b0, 1'b0, hz);
        chk("lduse_haz_drop", 64'(hz), 64'h0);
        chk("lduse_addu", 64'({ex_valid, aluop, dest}), 64'({1'b1, 4'd0, 5'd10}));

        cyc(ADDI_N4, 1'b1, 1'b0, 1'b0, 1'b0, hz);
        cyc(ADDU_DEP, 1'b1, 1'b1, 1'b1, 1'b0, hz);
        chk("flush_over_stall", 64'(dut_st()), 64'h0);

        cyc(ADDI_N4, 1'b1, 1'b0, 1'b0, 1'b0, hz);
        for (int i = 0; i < 3; i++) begin
            cyc(enc_i(6'h0d, 1, 3, 16'h00FF), 1'b1, 1'b1, 1'b0, 1'b0, hz);
            chk($sformatf("stall_hold%0d", i), 64'({ex_valid, aluop, imm_ext}), 64'({1'b1, 4'd6, 32'hFFFFFFFC}));
        end

        cyc(LW_T0, 1'b1, 1'b0, 1'b0, 1'b0, hz);
        cyc(ADDU_DEP, 1'b1, 1'b1, 1'b0, 1'b0, hz);
        chk("stall_haz_asserted", 64'(hz), 64'h1);
        chk("stall_haz_hold", 64'({ex_valid, aluop, memread}), 64'({1'b1, 4'd11, 1'b1}));
        cyc(ADDU_DEP, 1'b1, 1'b0, 1'b0, 1'b0, hz);
        chk("stall_haz_then_bubble", 64'({hz, ex_valid}), 64'({1'b1, 1'b0}));

        cyc(32'hFC000000, 1'b1, 1'b0, 1'b0, 1'b0, hz);
        cyc(enc_i(6'h2b, 9, 8, 16'h0004), 1'b1, 1'b0, 1'b0, 1'b0, hz);
        chk("sw_loaded", 64'({ex_valid, aluop, memwrite}), 64'({1'b1, 4'd12, 1'b1}));
        cyc(ADDU_DEP, 1'b1, 1'b0, 1'b0, 1'b1, hz);
        chk("midstream_reset", 64'(dut_st()), 64'h0);
        chk("midstream_reset_illegal", 64'(illegal), 64'h0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            int sel;
            int row;
            sel = $urandom_range(0, 99);
            row = $urandom_range(0, 13);
            if (sel < 60)
                ins = (KIND[row] == 0) ? enc_r(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), CODE[row])
                                       : enc_i(CODE[row], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom));
            else if (sel < 68) ins = 32'h0;
            else if (sel < 80) ins = enc_r(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 6'($urandom));
            else ins = $urandom;
            cyc(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 49) == 0, hz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
